if_fetch_ctrl: RTL and testbench

Fetch-stage sequencer for the 5-stage in-order core. It owns the fetch PC and drives the instruction-SRAM request/address-ok/data-ok handshake. It buffers one returned instruction and presents it to the IF/ID pipeline register as a PC/instruction pair with a one-cycle load enable. It also cancels wrong-path fetches on branch redirects.

---
 rtl/if_fetch_ctrl_if.sv | 29 ++
 rtl/if_fetch_ctrl.sv | 95 +++++++++
 tb/tb_if_fetch_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-SRAM request channel between the fetch sequencer (master)
// and the instruction memory (slave).
interface if_fetch_ctrl_if;
  // A request transfers on a cycle where inst_sram_req and inst_sram_addr_ok are
  // both 1; while req=1 and addr_ok=0 the master holds req/addr stable. One
  // inst_sram_data_ok pulse, carrying inst_sram_rdata, answers each accepted
  // request, and at most one request is outstanding at a time.
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  modport master (
    output inst_sram_req,
    output inst_sram_addr,
    input  inst_sram_addr_ok,
    input  inst_sram_data_ok,
    input  inst_sram_rdata
  );

  modport slave (
    input  inst_sram_req,
    input  inst_sram_addr,
    output inst_sram_addr_ok,
    output inst_sram_data_ok,
    output inst_sram_rdata
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, runs one SRAM request at a time,
// buffers the returned word and cancels wrong-path fetches on redirect.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   id_allowin,
  input  logic                   br_taken,
  input  logic [31:0]            br_target,
  if_fetch_ctrl_if.master        sram,
  output logic                   if_ready_go,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_inst,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] fetch_pc_q;
  logic        cancel_q;
  logic [31:0] hold_pc_q;
  logic [31:0] hold_inst_q;

  logic [31:0] br_pc_d;
  logic [31:0] seq_pc_d;

  assign br_pc_d  = br_target & ~32'h3;
  assign seq_pc_d = hold_pc_q + 32'd4;

  assign sram.inst_sram_req  = (state_q == REQ);
  assign sram.inst_sram_addr = {fetch_pc_q[31:2], 2'b00};
  assign if_ready_go         = (state_q == HOLD) & id_allowin & ~br_taken;
  assign if_pc               = hold_pc_q;
  assign if_inst             = hold_inst_q;
  assign dbg_state_o         = state_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      cancel_q    <= 1'b0;
      hold_pc_q   <= RESET_PC - 32'd4;
      hold_inst_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;

        REQ: begin
          if (br_taken) fetch_pc_q <= br_pc_d;
          if (sram.inst_sram_addr_ok) begin
            // The pre-redirect address was already accepted; its data must be dropped.
            state_q   <= WAIT;
            hold_pc_q <= fetch_pc_q;
            cancel_q  <= br_taken;
          end
        end

        WAIT: begin
          if (br_taken) fetch_pc_q <= br_pc_d;
          if (sram.inst_sram_data_ok) begin
            cancel_q <= 1'b0;
            if (cancel_q || br_taken) begin
              state_q <= REQ;
            end else begin
              hold_inst_q <= sram.inst_sram_rdata;
              state_q     <= HOLD;
            end
          end else if (br_taken) begin
            cancel_q <= 1'b1;
          end
        end

        HOLD: begin
          if (br_taken) begin
            fetch_pc_q <= br_pc_d;
            state_q    <= REQ;
          end else if (id_allowin) begin
            fetch_pc_q <= seq_pc_d;
            state_q    <= REQ;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed table-driven bench for if_fetch_ctrl plus a short responder sequence.
module tb_if_fetch_ctrl;

  logic        clk;
  logic        resetn;
  logic        id_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        if_ready_go;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [1:0]  dbg_state;

  if_fetch_ctrl_if sram ();

  if_fetch_ctrl dut (
    .clk         (clk),
    .resetn      (resetn),
    .id_allowin  (id_allowin),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .sram        (sram.master),
    .if_ready_go (if_ready_go),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rstn;
    logic        allow;
    logic        br;
    logic [31:0] tgt;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_rg;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] exp_q[$];

  localparam logic [31:0] I0 = 32'h11110000;
  localparam logic [31:0] I1 = 32'h11110004;
  localparam logic [31:0] I2 = 32'h22220000;
  localparam logic [31:0] I3 = 32'h33330000;
  localparam logic [31:0] I4 = 32'h44440000;
  localparam logic [31:0] BAD = 32'hdeadbeef;
  localparam logic [31:0] RPC = 32'h1bfffffc;

  task automatic add(input logic rstn, input logic allow, input logic br, input logic [31:0] tgt,
                     input logic aok, input logic dok, input logic [31:0] rdata,
                     input logic e_req, input logic [31:0] e_addr, input logic e_rg,
                     input logic [31:0] e_pc, input logic [31:0] e_inst, input logic [1:0] e_st);
    vec_t v;
    v.rstn = rstn; v.allow = allow; v.br = br; v.tgt = tgt; v.aok = aok; v.dok = dok;
    v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr; v.e_rg = e_rg; v.e_pc = e_pc;
    v.e_inst = e_inst; v.e_st = e_st;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: apply one row, compare just after, then move to the next negedge.
  task automatic step(input vec_t v, input int idx);
    resetn                 = v.rstn;
    id_allowin             = v.allow;
    br_taken               = v.br;
    br_target              = v.tgt;
    sram.inst_sram_addr_ok = v.aok;
    sram.inst_sram_data_ok = v.dok;
    sram.inst_sram_rdata   = v.rdata;
    #1;
    chk($sformatf("row%0d req", idx),   {31'd0, sram.inst_sram_req}, {31'd0, v.e_req});
    chk($sformatf("row%0d addr", idx),  sram.inst_sram_addr, v.e_addr);
    chk($sformatf("row%0d rg", idx),    {31'd0, if_ready_go}, {31'd0, v.e_rg});
    chk($sformatf("row%0d pc", idx),    if_pc, v.e_pc);
    chk($sformatf("row%0d inst", idx),  if_inst, v.e_inst);
    chk($sformatf("row%0d state", idx), {30'd0, dbg_state}, {30'd0, v.e_st});
    @(negedge clk);
  endtask

  // Slave-side responder for one fetch: accept at once, answer after lat idle cycles.
  task automatic fetch_one(input logic [31:0] pc, input int lat);
    logic [31:0] exp_inst;
    int budget;
    exp_inst = pc ^ 32'h5a5a0000;
    exp_q.push_back(exp_inst);
    id_allowin = 1'b1;
    br_taken = 1'b0;
    budget = 0;
    while (!sram.inst_sram_req && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    sram.inst_sram_addr_ok = 1'b1;
    #1;
    chk("seq req", {31'd0, sram.inst_sram_req}, 32'd1);
    chk("seq addr", sram.inst_sram_addr, pc);
    @(negedge clk);
    sram.inst_sram_addr_ok = 1'b0;
    for (int i = 0; i < lat; i++) begin
      #1;
      chk("seq wait req", {31'd0, sram.inst_sram_req}, 32'd0);
      @(negedge clk);
    end
    sram.inst_sram_data_ok = 1'b1;
    sram.inst_sram_rdata = exp_inst;
    @(negedge clk);
    sram.inst_sram_data_ok = 1'b0;
    sram.inst_sram_rdata = 32'd0;
    budget = 0;
    while (!if_ready_go && budget < 10) begin
      #1;
      if (!if_ready_go) begin
        @(negedge clk);
        budget++;
      end
    end
    chk("seq rg", {31'd0, if_ready_go}, 32'd1);
    chk("seq pc", if_pc, pc);
    chk("seq inst", if_inst, exp_q.pop_front());
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    id_allowin = 1'b0;
    br_taken = 1'b0;
    br_target = 32'd0;
    sram.inst_sram_addr_ok = 1'b0;
    sram.inst_sram_data_ok = 1'b0;
    sram.inst_sram_rdata = 32'd0;

    //   rstn allow br tgt           aok dok rdata  req addr          rg pc            inst st
    add(1, 1, 0, 32'h0,          0, 0, 32'h0, 0, 32'h1c000000, 0, RPC,          32'h0, 2'd0);
    add(1, 1, 0, 32'h0,          1, 0, 32'h0, 1, 32'h1c000000, 0, RPC,          32'h0, 2'd1);
    add(1, 1, 0, 32'h0,          0, 1, I0,    0, 32'h1c000000, 0, 32'h1c000000, 32'h0, 2'd2);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0, 0, 32'h1c000000, 1, 32'h1c000000, I0,    2'd3);
    add(1, 1, 0, 32'h0,          1, 0, 32'h0, 1, 32'h1c000004, 0, 32'h1c000000, I0,    2'd1);
    add(1, 1, 0, 32'h0,          0, 1, I1,    0, 32'h1c000004, 0, 32'h1c000004, I0,    2'd2);
    for (int i = 0; i < 5; i++)
      add(1, 0, 0, 32'h0,        0, 0, 32'h0, 0, 32'h1c000004, 0, 32'h1c000004, I1,    2'd3);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0, 0, 32'h1c000004, 1, 32'h1c000004, I1,    2'd3);
    add(1, 1, 1, 32'h1c000100,   1, 0, 32'h0, 1, 32'h1c000008, 0, 32'h1c000004, I1,    2'd1);
    add(1, 1, 0, 32'h0,          0, 1, BAD,   0, 32'h1c000100, 0, 32'h1c000008, I1,    2'd2);
    add(1, 1, 0, 32'h0,          1, 0, 32'h0, 1, 32'h1c000100, 0, 32'h1c000008, I1,    2'd1);
    add(1, 1, 0, 32'h0,          0, 1, I2,    0, 32'h1c000100, 0, 32'h1c000100, I1,    2'd2);
    add(1, 1, 1, 32'h1c000200,   0, 0, 32'h0, 0, 32'h1c000100, 0, 32'h1c000100, I2,    2'd3);
    add(1, 1, 0, 32'h0,          1, 0, 32'h0, 1, 32'h1c000200, 0, 32'h1c000100, I2,    2'd1);
    add(1, 1, 1, 32'hfffffffe,   0, 0, 32'h0, 0, 32'h1c000200, 0, 32'h1c000200, I2,    2'd2);
    add(1, 1, 0, 32'h0,          0, 1, BAD,   0, 32'hfffffffc, 0, 32'h1c000200, I2,    2'd2);
    for (int i = 0; i < 4; i++)
      add(1, 1, 0, 32'h0,        0, 0, 32'h0, 1, 32'hfffffffc, 0, 32'h1c000200, I2,    2'd1);
    add(1, 1, 0, 32'h0,          1, 0, 32'h0, 1, 32'hfffffffc, 0, 32'h1c000200, I2,    2'd1);
    add(1, 1, 0, 32'h0,          0, 1, I3,    0, 32'hfffffffc, 0, 32'hfffffffc, I2,    2'd2);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0, 0, 32'hfffffffc, 1, 32'hfffffffc, I3,    2'd3);
    add(1, 1, 0, 32'h0,          1, 0, 32'h0, 1, 32'h00000000, 0, 32'hfffffffc, I3,    2'd1);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0, 0, 32'h00000000, 0, 32'h00000000, I3,    2'd2);
    add(1, 1, 0, 32'h0,          0, 1, I4,    0, 32'h00000000, 0, 32'h00000000, I3,    2'd2);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0, 0, 32'h00000000, 1, 32'h00000000, I4,    2'd3);
    add(1, 1, 0, 32'h0,          1, 0, 32'h0, 1, 32'h00000004, 0, 32'h00000000, I4,    2'd1);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0, 0, 32'h00000004, 0, 32'h00000004, I4,    2'd2);
    // Reset while a request is outstanding, then redirect corner cases.
    add(0, 0, 0, 32'h0,          0, 0, 32'h0, 0, 32'h00000004, 0, 32'h00000004, I4,    2'd2);
    add(1, 1, 1, 32'h12345678,   0, 0, 32'h0, 0, 32'h1c000000, 0, RPC,          32'h0, 2'd0);
    add(1, 1, 1, 32'h1c000300,   0, 0, 32'h0, 1, 32'h1c000000, 0, RPC,          32'h0, 2'd1);
    add(1, 1, 0, 32'h0,          1, 0, 32'h0, 1, 32'h1c000300, 0, RPC,          32'h0, 2'd1);
    add(1, 1, 1, 32'h1c000400,   0, 1, BAD,   0, 32'h1c000300, 0, 32'h1c000300, 32'h0, 2'd2);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0, 1, 32'h1c000400, 0, 32'h1c000300, 32'h0, 2'd1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset req",   {31'd0, sram.inst_sram_req}, 32'd0);
    chk("reset rg",    {31'd0, if_ready_go}, 32'd0);
    chk("reset pc",    if_pc, RPC);
    chk("reset inst",  if_inst, 32'd0);
    chk("reset state", {30'd0, dbg_state}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    fetch_one(32'h1c000400, 0);
    fetch_one(32'h1c000404, 2);
    fetch_one(32'h1c000408, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
